// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared constants and select-code helpers for the hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int FWD_NONE = 0;

    function automatic int sel_width(input int lanes, input int stages);
        return $clog2(lanes * stages + 1);
    endfunction

    // Lower code = higher priority: youngest stage first, then highest lane.
    function automatic int sel_code(input int stage, input int lane, input int lanes);
        return 1 + stage * lanes + (lanes - 1 - lane);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - matches one EX source register against every in-flight tag
module hazard_src_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int STAGES     = 2,
    parameter int REG_W      = 5,
    parameter int LOAD_READY = 1,
    parameter int SEL_W      = 3
) (
    input  logic [REG_W-1:0]              rs_i,
    input  logic [LANES*STAGES-1:0]       tag_valid_i,
    input  logic [LANES*STAGES-1:0]       tag_load_i,
    input  logic [LANES*STAGES*REG_W-1:0] tag_rd_i,
    output logic [SEL_W-1:0]              sel_o,
    output logic                          load_hit_o
);

    // Walk from lowest to highest priority so the last match is the winner.
    always_comb begin
        sel_o      = SEL_W'(FWD_NONE);
        load_hit_o = 1'b0;
        if (rs_i != '0) begin
            for (int k = STAGES - 1; k >= 0; k--) begin
                for (int i = 0; i < LANES; i++) begin
                    if (tag_valid_i[k*LANES+i] &&
                        (tag_rd_i[(k*LANES+i)*REG_W +: REG_W] == rs_i)) begin
                        sel_o      = SEL_W'(sel_code(k, i, LANES));
                        load_hit_o = tag_load_i[k*LANES+i] && (k < LOAD_READY);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shadow tag pipeline, operand forward selects and load-use stall
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int LANES      = 2,
    parameter  int STAGES     = 2,
    parameter  int REG_W      = 5,
    parameter  int LOAD_READY = 1,
    parameter  int CNT_W      = 32,
    localparam int SEL_W      = sel_width(LANES, STAGES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [LANES-1:0]           ex_valid,
    input  logic [LANES-1:0]           ex_we,
    input  logic [LANES-1:0]           ex_is_load,
    input  logic [LANES*REG_W-1:0]     ex_rd,
    input  logic [LANES*2*REG_W-1:0]   ex_rs,
    input  logic                       flush,
    output logic [LANES*2*SEL_W-1:0]   fwd_sel,
    output logic                       stall,
    output logic [CNT_W-1:0]           stall_count
);

    localparam int N = LANES * STAGES;

    // Tag slot k*LANES+i holds stage k, lane i.
    logic [N-1:0]       valid_q, valid_d;
    logic [N-1:0]       load_q, load_d;
    logic [N*REG_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [LANES*2-1:0]       hit;
    logic [LANES*2*SEL_W-1:0] raw_sel;
    logic                     stall_w;
    logic [LANES*2*SEL_W-1:0] fwd_sel_w;

    for (genvar s = 0; s < LANES * 2; s++) begin : g_src
        hazard_src_match #(
            .LANES     (LANES),
            .STAGES    (STAGES),
            .REG_W     (REG_W),
            .LOAD_READY(LOAD_READY),
            .SEL_W     (SEL_W)
        ) u_match (
            .rs_i       (ex_rs[s*REG_W +: REG_W]),
            .tag_valid_i(valid_q),
            .tag_load_i (load_q),
            .tag_rd_i   (rd_q),
            .sel_o      (raw_sel[s*SEL_W +: SEL_W]),
            .load_hit_o (hit[s])
        );
    end

    always_comb begin
        stall_w   = 1'b0;
        fwd_sel_w = raw_sel;
        for (int s = 0; s < LANES * 2; s++) begin
            if (ex_valid[s/2] && hit[s]) begin
                stall_w                       = 1'b1;
                fwd_sel_w[s*SEL_W +: SEL_W]   = SEL_W'(FWD_NONE);
            end
        end
    end

    always_comb begin
        valid_d = valid_q << LANES;
        load_d  = load_q << LANES;
        rd_d    = rd_q << (LANES * REG_W);
        if (flush) begin
            valid_d = '0;
        end else if (!stall_w) begin
            for (int i = 0; i < LANES; i++) begin
                valid_d[i] = ex_valid[i] && ex_we[i] && (ex_rd[i*REG_W +: REG_W] != '0);
                load_d[i]  = ex_is_load[i];
            end
            rd_d[LANES*REG_W-1:0] = ex_rd;
        end
    end

    always_comb begin
        count_d = count_q;
        if (stall_w && !flush && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            load_q  <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            load_q  <= load_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign fwd_sel     = fwd_sel_w;
    assign stall       = stall_w;
    assign stall_count = count_q;

endmodule
